// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared core-wide constants and types used by the front end
//            (fetch buffer, decoder and PC pipeline).
// Contents : XLEN            - datapath / instruction width
//            FETCH_BUF_DEPTH - default number of fetch buffer entries
//            fetch_entry_t   - {instr, pc} pair held in the fetch buffer
//            INSTR_BUBBLE    - word presented to decode when nothing is valid
// Revision : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN            = 32;
  localparam int FETCH_BUF_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // All-zero word decodes as an unknown opcode, so it never dispatches.
  localparam logic [XLEN-1:0] INSTR_BUBBLE = 32'h0;

endpackage : core_pkg
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_buffer
// Purpose  : Circular instruction queue between fetch and decode. Buffers
//            instruction words with their PCs so fetch can keep running
//            while decode stalls; presents the oldest entry via valid/ready.
// Ports    : clk        - clock, all state updates on the rising edge
//            reset_n    - synchronous active-low reset
//            flush      - discard all entries (redirect)
//            in_valid   - fetch offers an instruction
//            in_ready   - buffer can accept this cycle (not full)
//            in_instr   - fetched instruction word
//            in_pc      - PC of in_instr
//            out_valid  - head entry valid for decode (not empty)
//            out_ready  - decode consumes the head this cycle
//            out_instr  - head instruction, zero when out_valid = 0
//            out_pc     - head PC, zero when out_valid = 0
//            count      - number of occupied entries, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module fetch_buffer #(
  parameter int DEPTH = core_pkg::FETCH_BUF_DEPTH,
  parameter int XLEN  = core_pkg::XLEN
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  // Storage is deliberately not reset; only the pointers define validity.
  logic [XLEN-1:0] r_mem_instr [DEPTH];
  logic [XLEN-1:0] r_mem_pc    [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;

  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [AW-1:0]   w_widx;
  logic [AW-1:0]   w_ridx;

  assign w_widx  = r_wptr[AW-1:0];
  assign w_ridx  = r_rptr[AW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (w_widx == w_ridx) && (r_wptr[AW] != r_rptr[AW]);
  assign w_push  = in_valid && !w_full;
  assign w_pop   = !w_empty && out_ready;

  always_ff @(posedge clk) begin
    // A write landing during reset/flush is harmless: the pointers are
    // cleared in the same edge, so the slot is never considered valid.
    if (w_push) begin
      r_mem_instr[w_widx] <= in_instr;
      r_mem_pc[w_widx]    <= in_pc;
    end

    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  // Outputs depend only on registered state; no fall-through from in_*.
  always_comb begin
    in_ready  = !w_full;
    out_valid = !w_empty;
    out_instr = '0;
    out_pc    = '0;
    if (!w_empty) begin
      out_instr = r_mem_instr[w_ridx];
      out_pc    = r_mem_pc[w_ridx];
    end
    // Natural wrap of the AW+1 bit subtraction gives modulo 2*DEPTH.
    count = r_wptr - r_rptr;
  end

endmodule : fetch_buffer
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_buffer
// Purpose  : Directed self-checking bench for fetch_buffer (DEPTH=4, XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int vectors;
  int miscompares;

  fetch_buffer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL reset_out_instr: got %h expected 00000000", out_instr); end
    // Single push into empty buffer appears one cycle later.
    push_one(32'h00500093, 32'h0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
    vectors++; if (out_instr !== 32'h00500093) begin miscompares++; $display("FAIL single_out_instr: got %h expected 00500093", out_instr); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL single_out_pc: got %h expected 00000000", out_pc); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", count); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL single_drained: got %0d expected 0", count); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_one(32'h10000000 + 32'(i), 32'(4 * i));
    end
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_count: got %0d expected 4", count); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    push_one(32'hBAD00000, 32'd16);
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_overflow_count: got %0d expected 4", count); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, out_valid); end
      vectors++; if (out_pc !== 32'(4 * i)) begin miscompares++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, out_pc, 32'(4 * i)); end
      vectors++; if (out_instr !== 32'h10000000 + 32'(i)) begin miscompares++; $display("FAIL drain_instr[%0d]: got %h expected %h", i, out_instr, 32'h10000000 + 32'(i)); end
      tick();
    end
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_empty_valid: got %b expected 0", out_valid); end
    vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL drain_empty_instr: got %h expected 00000000", out_instr); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL drain_empty_count: got %0d expected 0", count); end
  endtask

  task automatic test_wrap();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_instr = 32'h20000000 + 32'(k);
      in_pc    = 32'(4 * k);
      tick();
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL wrap_valid[%0d]: got %b expected 1", k, out_valid); end
      vectors++; if (out_pc !== 32'(4 * k)) begin miscompares++; $display("FAIL wrap_pc[%0d]: got %h expected %h", k, out_pc, 32'(4 * k)); end
      vectors++; if (out_instr !== 32'h20000000 + 32'(k)) begin miscompares++; $display("FAIL wrap_instr[%0d]: got %h expected %h", k, out_instr, 32'h20000000 + 32'(k)); end
      vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL wrap_count[%0d]: got %0d expected 1", k, count); end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_end_valid: got %b expected 0", out_valid); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL wrap_end_count: got %0d expected 0", count); end
  endtask

  task automatic test_flush();
    push_one(32'h30000000, 32'h40);
    push_one(32'h30000001, 32'h44);
    push_one(32'h30000002, 32'h48);
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'hDEADBEEF;
    in_pc     = 32'h4C;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL flush_count: got %0d expected 0", count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL flush_instr: got %h expected 00000000", out_instr); end
    push_one(32'h00A00113, 32'h100);
    vectors++; if (out_pc !== 32'h100) begin miscompares++; $display("FAIL flush_new_pc: got %h expected 00000100", out_pc); end
    vectors++; if (out_instr !== 32'h00A00113) begin miscompares++; $display("FAIL flush_new_instr: got %h expected 00a00113", out_instr); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL flush_new_count: got %0d expected 1", count); end
  endtask

  task automatic test_reset_mid();
    // One entry left from the flush test; add one more.
    push_one(32'h00B00193, 32'h104);
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL rstmid_pre_count: got %0d expected 2", count); end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rstmid_count: got %0d expected 0", count); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL rstmid_pc: got %h expected 00000000", out_pc); end
    // Reset together with flush and a push offer.
    push_one(32'h00C00213, 32'h200);
    reset_n  = 1'b0;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h11111111;
    in_pc    = 32'h204;
    tick();
    reset_n  = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rstflush_count: got %0d expected 0", count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstflush_valid: got %b expected 0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstflush_in_ready: got %b expected 1", in_ready); end
    vectors++; if (out_instr !== 32'h0) begin miscompares++; $display("FAIL rstflush_instr: got %h expected 00000000", out_instr); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_instr    = 32'h0;
    in_pc       = 32'h0;
    out_ready   = 1'b0;
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fetch_buffer
`default_nettype wire
